capture_reader: RTL and testbench
=================================

# capture_reader

Read-out engine for the capture memory. After the sampler finishes a capture, `capture_reader` reads the 2^SAMPLE_DEPTH samples back out of the circular buffer, oldest-first and trigger-aligned. It streams them as bytes over a valid/ready interface toward the host link (UART TX). Both sides of the sample RAM sit in the `clk_50mhz` domain.

## Interface
Parameters:
- `SAMPLE_DEPTH`, 8, address width; capture length N = 2^SAMPLE_DEPTH (256).
- `PRE_TRIG`, 2^(SAMPLE_DEPTH-1) (128), samples delivered before the trigger sample.

Ports:
- `clk_50mhz`  in  1  sole clock.
- `reset`  in  1  reset; one clock; synchronous, active-high.
- `start`  in  1  request read-out; sampled only in IDLE.
- `trig_addr`  in  SAMPLE_DEPTH  RAM address holding the trigger sample; latched on accepted `start`.
- `busy`  out  1  high from accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse after the last byte is accepted.
- `mem_re`  out  1  read strobe to sample RAM.
- `mem_addr`  out  SAMPLE_DEPTH  read address, valid with `mem_re`.
- `mem_rdata`  in  8  RAM data; valid exactly one cycle after `mem_re`.
- `out_data`  out  8  sample byte.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready` at a rising edge.
- `out_last`  out  1  high with the Nth (final) byte.

## Operation
- States: IDLE, STREAM, DONE.
- **IDLE**
  - `busy`=0.
  - On `start`=1: latch `base = trig_addr - PRE_TRIG` (mod N, SAMPLE_DEPTH-bit wrap).
  - Clear `issued` and `sent` counters (SAMPLE_DEPTH+1 bits each). Go to STREAM.
- **STREAM**
  - Issue read `k` at address `base + k` (mod N), for k = 0..N-1.
  - `mem_re`=1 when `issued < N` and `fifo_count + inflight - pop < 2`, where `pop = out_valid && out_ready` in the same cycle.
  - `inflight` is 1 if `mem_re` was asserted in the previous cycle.
  - Returned data is pushed into a 2-entry FIFO the cycle it arrives. The FIFO never overflows by construction; an overflow is an assertion failure.
  - `out_valid` = FIFO non-empty; `out_data` = FIFO head.
  - `sent` increments on each handshake. When the handshake has `sent == N-1`, go to DONE.
- **DONE**: `done`=1 for one cycle, `busy` still 1, then IDLE.
- Delivered order: N bytes, oldest-first. The trigger sample is byte index PRE_TRIG (129th).
- `start` while not in IDLE is ignored; `trig_addr` is not re-latched.
- `reset` in any state:
  - next state IDLE;
  - FIFO, counters and in-flight read discarded;
  - a RAM word returning after reset is dropped.
- Reset values: `busy`, `done`, `mem_re`, `out_valid`, `out_last` = 0; `mem_addr`, `out_data` = 0.

## Timing
- `start` sampled at edge E0 → `mem_re`=1, `mem_addr`=base in cycle 1 → data pushed at E2 → `out_valid`=1 in cycle 3. Start-to-first-valid latency is 3 cycles.
- With `out_ready` held 1: one byte per cycle, bytes in cycles 3..N+2, `done` in cycle N+3, `busy` low from cycle N+4.
- While `out_valid && !out_ready`:
  - `out_data` and `out_last` must hold stable;
  - `out_valid` must not drop;
  - reads stall once FIFO plus in-flight reaches 2.
- `out_last` = `out_valid && (sent == N-1)`.
- `mem_addr` holds its last value when `mem_re`=0.

## Structure
- Shared package `oscilo_pkg`:
  - `SAMPLE_DEPTH`;
  - `PRE_TRIG` derivation;
  - `reader_state_t` enum {IDLE, STREAM, DONE}.
  - The sampler uses the same package for its depth and pre-trigger count.
- One sub-module: `sample_fifo2`, a 2-entry 8-bit FIFO.
  - Ports: push/pop/data/count; synchronous reset.
  - Simultaneous push+pop is allowed when full or empty.
- Top level holds the FSM, counters, address generator and in-flight flag.

## Test plan
- Trigger at mid-buffer: RAM[i]=i, `trig_addr`=0x80, `out_ready`=1 → bytes 0x00..0xFF in order. `out_valid` first in cycle 3; `out_last` on 0xFF; `done` at cycle 259.
- Wrap-around: RAM[i]=i, `trig_addr`=0x10 → sequence 0x90..0xFF, 0x00..0x8F; 129th byte = 0x10.
- Backpressure: random `out_ready` (50%), plus a 20-cycle low stretch → no byte lost or duplicated, data stable while stalled, FIFO never exceeds 2, `mem_re` stalls.
- Ignored start: second `start` with `trig_addr`=0x00 mid-stream of a 0x80 capture → stream unchanged; exactly one `done`.
- Mid-stream reset: assert `reset` after 40 bytes while a read is in flight → next cycle all outputs 0, `busy`=0. New `start` yields a full clean 256-byte stream.
- Back-to-back: `start` held high through `done` → second read-out begins from IDLE the cycle after `done`, again with 3-cycle latency.

Source files
------------

// File: rtl/oscilo_pkg.sv
// Shared capture-memory constants and the read-out FSM state type, used by both
// the sampler and the reader so depth and pre-trigger count always agree.
package oscilo_pkg;

  localparam int SAMPLE_DEPTH = 8;

  function automatic int pre_trig_of(input int depth);
    return 1 << (depth - 1);
  endfunction

  localparam int PRE_TRIG = pre_trig_of(SAMPLE_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } reader_state_t;

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry byte FIFO between the sample RAM read port and the byte stream.
// A pop on an empty FIFO is ignored; push and pop may coincide when full or empty.
module sample_fifo2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic [1:0] o_count
);

  logic [7:0] r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      assert (!(i_push && !w_pop && (r_count == 2'd2)));
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/capture_reader.sv
// Streams a finished capture out of the circular sample RAM, oldest sample first,
// so that the trigger sample lands at byte index PRE_TRIG.
module capture_reader #(
  parameter int SAMPLE_DEPTH = oscilo_pkg::SAMPLE_DEPTH,
  parameter int PRE_TRIG     = oscilo_pkg::PRE_TRIG
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SAMPLE_DEPTH-1:0] trig_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_re,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  input  logic [7:0]              mem_rdata,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);
  import oscilo_pkg::*;

  localparam int                    CNT_W    = SAMPLE_DEPTH + 1;
  localparam logic [CNT_W-1:0]      N_CNT    = CNT_W'(1) << SAMPLE_DEPTH;
  localparam logic [CNT_W-1:0]      LAST_CNT = N_CNT - CNT_W'(1);
  localparam logic [SAMPLE_DEPTH-1:0] PRE_OFF = SAMPLE_DEPTH'(PRE_TRIG);

  reader_state_t           r_state;
  logic [SAMPLE_DEPTH-1:0] r_base;
  logic [SAMPLE_DEPTH-1:0] r_addr_hold;
  logic [CNT_W-1:0]        r_issued;
  logic [CNT_W-1:0]        r_sent;
  logic                    r_inflight;

  logic [1:0]              w_fifo_count;
  logic [7:0]              w_head;
  logic                    w_pop;
  logic [2:0]              w_occ;
  logic                    w_room;
  logic                    w_mem_re;
  logic [SAMPLE_DEPTH-1:0] w_next_addr;

  // The RAM answers one cycle after the strobe, so the in-flight flag is the push.
  sample_fifo2 u_fifo (
    .i_clk   (clk_50mhz),
    .i_rst   (reset),
    .i_push  (r_inflight),
    .i_data  (mem_rdata),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  assign out_valid = (w_fifo_count != 2'd0);
  assign out_data  = w_head;
  assign out_last  = out_valid && (r_sent == LAST_CNT);
  assign w_pop     = out_valid && out_ready;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

  // A slot freed by this cycle's pop may be refilled immediately, keeping one byte per cycle.
  assign w_occ       = {1'b0, w_fifo_count} + {2'b0, r_inflight};
  assign w_room      = w_occ < (3'd2 + {2'b0, w_pop});
  assign w_mem_re    = (r_state == STREAM) && (r_issued < N_CNT) && w_room;
  assign w_next_addr = r_base + r_issued[SAMPLE_DEPTH-1:0];
  assign mem_re      = w_mem_re;
  assign mem_addr    = w_mem_re ? w_next_addr : r_addr_hold;

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_addr_hold <= '0;
      r_issued    <= '0;
      r_sent      <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_mem_re;
      if (w_mem_re) begin
        r_issued    <= r_issued + CNT_W'(1);
        r_addr_hold <= w_next_addr;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base   <= trig_addr - PRE_OFF;
            r_issued <= '0;
            r_sent   <= '0;
            r_state  <= STREAM;
          end
        end
        STREAM: begin
          if (w_pop) begin
            r_sent <= r_sent + CNT_W'(1);
            if (r_sent == LAST_CNT) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_reader.sv
// Directed bench for capture_reader: RAM holds RAM[i]=i, so byte k of a read-out
// triggered at T must equal (T - 0x80 + k) mod 256.
module tb_capture_reader;

  logic       clk_50mhz = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] trig_addr;
  logic       busy;
  logic       done;
  logic       mem_re;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  logic [7:0] ram [256];
  int         n_checks = 0;
  int         n_errors = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  capture_reader dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .start     (start),
    .trig_addr (trig_addr),
    .busy      (busy),
    .done      (done),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always @(posedge clk_50mhz) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  // Called in cycle 1 (the cycle after start was sampled). Returns in the done cycle,
  // or right after the stop_after-th handshake when stop_after is non-zero.
  // mode 0: ready=1; mode 1: random ready plus a low stretch; mode 2: extra start mid-stream.
  task automatic collect(input logic [7:0] trig, input int mode, input int stop_after,
                         output int nbytes, output int first_vld, output int done_cyc,
                         output logic [7:0] trig_byte);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [7:0] exp_b;
    nbytes = 0; first_vld = -1; done_cyc = -1; trig_byte = 8'h00;
    prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      if (mode == 1) out_ready = (cyc >= 60 && cyc < 80) ? 1'b0 : 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      if (mode == 2 && cyc == 50) begin start = 1'b1; trig_addr = 8'h00; end
      if (mode == 2 && cyc == 51) start = 1'b0;
      #1;
      if (mode == 1 && cyc == 79) begin
        check("stall_mem_re", mem_re, 0);
        check("stall_valid", out_valid, 1);
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        exp_b = trig - 8'h80 + 8'(nbytes);
        check("byte", out_data, exp_b);
        check("last", out_last, 32'(nbytes == 255));
        if (nbytes == 128) trig_byte = out_data;
        nbytes++;
        if (stop_after != 0 && nbytes == stop_after) return;
      end
      if (done) begin
        done_cyc = cyc;
        check("done_busy", busy, 1);
        break;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      tick();
    end
    if (stop_after == 0) check("done_seen", 32'(done_cyc >= 0), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_re"}, mem_re, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  initial begin
    int         nb, fv, dc, extra;
    logic [7:0] tb8;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    reset = 1'b1; start = 1'b0; trig_addr = 8'h00; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_idle_outputs("rst");

    // Mid-buffer trigger
    start = 1'b1; trig_addr = 8'h80;
    tick();
    start = 1'b0;
    check("c1_mem_re", mem_re, 1);
    check("c1_addr", mem_addr, 8'h00);
    check("c1_busy", busy, 1);
    collect(8'h80, 0, 0, nb, fv, dc, tb8);
    check("mid_nbytes", nb, 256);
    check("mid_first", fv, 3);
    check("mid_done", dc, 259);
    check("mid_trig", tb8, 8'h80);
    tick();
    check("mid_busy_low", busy, 0);

    // Wrap-around trigger
    start = 1'b1; trig_addr = 8'h10;
    tick();
    start = 1'b0;
    check("wrap_addr", mem_addr, 8'h90);
    collect(8'h10, 0, 0, nb, fv, dc, tb8);
    check("wrap_nbytes", nb, 256);
    check("wrap_done", dc, 259);
    check("wrap_trig", tb8, 8'h10);
    tick();

    // Backpressure
    start = 1'b1; trig_addr = 8'h80;
    tick();
    start = 1'b0;
    collect(8'h80, 1, 0, nb, fv, dc, tb8);
    check("bp_nbytes", nb, 256);
    check("bp_first", fv, 3);
    check("bp_trig", tb8, 8'h80);
    tick();
    check("bp_busy_low", busy, 0);

    // Start while streaming is ignored
    start = 1'b1; trig_addr = 8'h80;
    tick();
    start = 1'b0;
    collect(8'h80, 2, 0, nb, fv, dc, tb8);
    check("ign_nbytes", nb, 256);
    check("ign_done", dc, 259);
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done || busy) extra++;
    end
    check("ign_extra_done", extra, 0);

    // Reset mid-stream with a read in flight
    start = 1'b1; trig_addr = 8'h80;
    tick();
    start = 1'b0;
    collect(8'h80, 0, 40, nb, fv, dc, tb8);
    check("rs_nbytes", nb, 40);
    check("rs_mem_re", mem_re, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("rs");
    tick();
    check("rs_drop_valid", out_valid, 0);
    start = 1'b1; trig_addr = 8'h10;
    tick();
    start = 1'b0;
    collect(8'h10, 0, 0, nb, fv, dc, tb8);
    check("rs_new_nbytes", nb, 256);
    check("rs_new_first", fv, 3);
    check("rs_new_done", dc, 259);
    tick();

    // Back-to-back with start held high
    start = 1'b1; trig_addr = 8'h80;
    tick();
    collect(8'h80, 0, 0, nb, fv, dc, tb8);
    check("b2b1_done", dc, 259);
    trig_addr = 8'h40;
    tick();
    check("b2b_idle_busy", busy, 0);
    tick();
    start = 1'b0;
    check("b2b2_mem_re", mem_re, 1);
    check("b2b2_addr", mem_addr, 8'hC0);
    collect(8'h40, 0, 0, nb, fv, dc, tb8);
    check("b2b2_nbytes", nb, 256);
    check("b2b2_first", fv, 3);
    check("b2b2_done", dc, 259);
    check("b2b2_trig", tb8, 8'h40);
    tick();
    check("b2b2_busy_low", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
